// File: rtl/regfile_pkg.sv
// Shared defaults and the write-port priority helper for the multi-port register file.
// Highest-indexed active port wins when several writes target one register.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_WR     = 4;

    function automatic logic [1:0] win_port(input logic [MAX_WR-1:0] hit);
        logic [1:0] win;
        win = 2'd0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (hit[i]) win = 2'(i);
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register mux, same-cycle write bypass, array mux.
// rd_data/rd_busy hold their value while rd_en is low.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [NUM_WR-1:0]             wr_ok,
    input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
    input  logic [DEPTH-1:0]              busy_rd,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_busy
);

    logic [MAX_WR-1:0] hit;
    logic [1:0]        win;
    logic [DATA_W-1:0] rd_data_d, rd_data_q, byp_data;
    logic              rd_busy_q;

    always_comb begin
        hit = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            hit[j] = wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr);
        end
        win = win_port(hit);
        byp_data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (hit[j] && win == 2'(j)) byp_data = wr_data[j*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
        if (ZERO_REG != 0 && rd_addr == '0) rd_data_d = '0;
        else if (BYPASS != 0 && |hit)      rd_data_d = byp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_busy_q <= 1'b0;
        end else if (rd_en) begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= busy_rd[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write bypass, zero register and
// a busy scoreboard used by the hazard unit to track in-flight producers.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0]             busy_q, busy_d, busy_wclr, busy_rd;
    logic [NUM_WR-1:0]            wr_ok;

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = wr_en[j] &&
                       !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0);
        end
    end

    // Reserve is applied after write clears so a newer producer keeps the bit set.
    always_comb begin
        busy_wclr = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) busy_wclr[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        busy_d = busy_wclr;
        if (rsv_en && !(ZERO_REG != 0 && rsv_addr == '0)) busy_d[rsv_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    assign busy_rd = (BYPASS != 0) ? busy_wclr : busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .clk    (clk),
            .rst_n  (rst_n),
            .rd_en  (rd_en[i]),
            .rd_addr(rd_addr[i*ADDR_W +: ADDR_W]),
            .wr_ok  (wr_ok),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .mem    (mem_q),
            .busy_rd(busy_rd),
            .rd_data(rd_data[i*DATA_W +: DATA_W]),
            .rd_busy(rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance, both
// with two write ports, driven by the same stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [31:0] busy_vec_a, busy_vec_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_a)
    );

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_en = 1'b1;
        rsv_addr = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst_rd_data",  rd_data_a, 64'h0);
        chk("rst_busy_vec", {busy_vec_a, busy_vec_b}, 64'h0);
        chk("rst_rd_busy",  {62'h0, rd_busy_a}, 64'h0);
        rst_n = 1'b1;

        // Reset asserted mid-cycle with state and a write in flight.
        wr(0, 5'd5, 32'hDEADBEEF); step(); idle();
        rd(0, 5'd5); rsv(5'd5); step(); idle();
        chk("pre_rst_data", {32'h0, rd_data_a[31:0]}, 64'hDEADBEEF);
        chk("pre_rst_busy", {32'h0, busy_vec_a}, 64'h20);
        wr(0, 5'd5, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data", {rd_data_a, rd_data_b}, 64'h0);
        chk("async_rst_busy", {busy_vec_a, busy_vec_b}, 64'h0);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b1;
        rd(0, 5'd5); step(); idle();
        chk("r5_after_rst", {rd_data_a[31:0], rd_data_b[31:0]}, 64'h0);

        // Zero register ignores writes and reserves.
        wr(0, 5'd0, 32'h1234); rsv(5'd0); rd(0, 5'd0); step(); idle();
        chk("r0_bypass_zero", {rd_data_a[31:0], rd_data_b[31:0]}, 64'h0);
        chk("r0_not_busy", {62'h0, busy_vec_a[0], busy_vec_b[0]}, 64'h0);
        rd(1, 5'd0); step(); idle();
        chk("r0_read_zero", {rd_data_a[63:32], rd_data_b[63:32]}, 64'h0);

        // Bypass on both read ports.
        wr(0, 5'd7, 32'hA5A5A5A5); rd(0, 5'd7); rd(1, 5'd7); step(); idle();
        chk("byp_r7", rd_data_a, 64'hA5A5A5A5_A5A5A5A5);
        chk("nobyp_r7_old", rd_data_b, 64'h0);
        rd(0, 5'd7); rd(1, 5'd7); step(); idle();
        chk("nobyp_r7_new", rd_data_b, 64'hA5A5A5A5_A5A5A5A5);

        // Two writes to one register: port 1 wins, including on the bypass path.
        wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rd(0, 5'd3); step(); idle();
        chk("prio_byp", {rd_data_a[31:0], rd_data_b[31:0]}, {32'h22, 32'h0});
        rd(0, 5'd3); step(); idle();
        chk("prio_r3", {rd_data_a[31:0], rd_data_b[31:0]}, {32'h22, 32'h22});

        // Scoreboard.
        rsv(5'd9); step(); idle();
        chk("rsv_r9", {busy_vec_a, busy_vec_b}, {32'h200, 32'h200});
        rd(0, 5'd9); step(); idle();
        chk("rd_busy_r9", {62'h0, rd_busy_a[0], rd_busy_b[0]}, 64'h3);
        wr(0, 5'd9, 32'h55); rd(0, 5'd9); step(); idle();
        chk("wr_clr_busy", {busy_vec_a, busy_vec_b}, 64'h0);
        chk("wr_clr_rd_a", {31'h0, rd_busy_a[0], rd_data_a[31:0]}, 64'h55);
        chk("wr_clr_rd_b", {31'h0, rd_busy_b[0], rd_data_b[31:0]}, {31'h0, 1'b1, 32'h0});
        wr(0, 5'd9, 32'h66); rsv(5'd9); rd(0, 5'd9); step(); idle();
        chk("wr_rsv_busy", {busy_vec_a, busy_vec_b}, {32'h200, 32'h200});
        chk("wr_rsv_rd_a", {31'h0, rd_busy_a[0], rd_data_a[31:0]}, 64'h66);
        chk("wr_rsv_rd_b", {31'h0, rd_busy_b[0], rd_data_b[31:0]}, 64'h55);

        // Read hold with rd_en low.
        rd_addr = {5'd3, 5'd3}; step(); idle();
        chk("hold", {rd_data_a[31:0], rd_data_b[31:0]}, {32'h66, 32'h55});

        // Flush overrides a same-edge reserve and leaves data intact.
        rsv(5'd2); step(); idle();
        rsv(5'd4); step(); idle();
        chk("busy_2_4_9", {32'h0, busy_vec_a}, 64'h214);
        flush = 1'b1; rsv(5'd6); step(); idle();
        chk("flush_busy", {busy_vec_a, busy_vec_b}, 64'h0);
        rd(0, 5'd3); rd(1, 5'd9); step(); idle();
        chk("flush_data_a", rd_data_a, {32'h66, 32'h22});
        chk("flush_data_b", rd_data_b, {32'h66, 32'h22});

        // Highest address through write port 1.
        wr(1, 5'd31, 32'hCAFEF00D); step(); idle();
        rd(0, 5'd30); rd(1, 5'd31); step(); idle();
        chk("r31_r30", rd_data_a, {32'hCAFEF00D, 32'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
